// File: rtl/trng_bit_packer.sv
// TRNG back end: decimates the mixer bit stream, runs a repetition-count health test,
// optionally von Neumann debiases, and packs bits into words behind a valid/ready register.
//
// state   | meaning
// IDLE    | not collecting; counters, shift register and history held clear
// COLLECT | sampling on every strobe, health-testing, debiasing and packing
// WAIT    | completed word held in the shift register, output full, sampling frozen
// FAIL    | repetition-count failure latched; waits for clr_fail
module trng_bit_packer #(
  parameter int WORD_W     = 32,
  parameter int SAMPLE_DIV = 16,
  parameter int RCT_LIMIT  = 32,
  parameter bit VN_EN      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              rct_fail,
  input  logic              clr_fail
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BIT_W = $clog2(WORD_W);
  localparam int REP_W = $clog2(RCT_LIMIT + 1);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(WORD_W - 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(RCT_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WAIT    = 2'd2,
    S_FAIL    = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] sr;
  logic              vn_phase;
  logic              vn_first;
  logic              have_last;
  logic              last_bit;
  logic [REP_W-1:0]  rep_cnt;

  logic              strobe;
  logic              load_wait;
  logic              clear_int;
  logic [REP_W-1:0]  rep_nx;
  logic              health_fail;
  logic              acc_valid;
  logic              acc_bit;
  logic              accept;
  logic              word_done;
  logic [WORD_W-1:0] word_new;
  logic              out_free;
  logic              load_collect;

  // Datapath decisions for the current strobe.
  always_comb begin
    rep_nx       = (have_last && (bit_in == last_bit)) ? rep_cnt + REP_W'(1) : REP_W'(1);
    health_fail  = strobe && (rep_nx == REP_MAX);
    acc_valid    = 1'b0;
    acc_bit      = 1'b0;
    if (VN_EN) begin
      acc_valid = strobe && vn_phase && (vn_first != bit_in);
      acc_bit   = vn_first;
    end else begin
      acc_valid = strobe;
      acc_bit   = bit_in;
    end
    accept       = acc_valid && !health_fail;
    word_new     = {sr[WORD_W-2:0], acc_bit};
    word_done    = accept && (bit_cnt == BIT_MAX);
    out_free     = !word_valid || word_ready;
    load_collect = word_done && out_free;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (enable) state_nx = S_COLLECT;
      S_COLLECT: begin
        if (health_fail)               state_nx = S_FAIL;
        else if (!enable)              state_nx = S_IDLE;
        else if (word_done && !out_free) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (!enable)         state_nx = S_IDLE;
        else if (word_ready) state_nx = S_COLLECT;
      end
      S_FAIL:    if (clr_fail) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    strobe    = (state == S_COLLECT) && (div_cnt == DIV_MAX);
    load_wait = (state == S_WAIT) && enable && word_ready;
    clear_int = (state_nx == S_IDLE) || (state_nx == S_FAIL);
  end

  // Collection state is wiped whenever the FSM is (or is about to be) idle or failed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      vn_phase  <= 1'b0;
      vn_first  <= 1'b0;
      have_last <= 1'b0;
      last_bit  <= 1'b0;
      rep_cnt   <= '0;
    end else if (clear_int) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      vn_phase  <= 1'b0;
      vn_first  <= 1'b0;
      have_last <= 1'b0;
      last_bit  <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      if (state == S_COLLECT)
        div_cnt <= strobe ? '0 : div_cnt + DIV_W'(1);
      if (strobe) begin
        last_bit  <= bit_in;
        have_last <= 1'b1;
        rep_cnt   <= rep_nx;
        vn_phase  <= ~vn_phase;
        if (!vn_phase) vn_first <= bit_in;
      end
      if (accept) begin
        sr      <= word_new;
        bit_cnt <= word_done ? '0 : bit_cnt + BIT_W'(1);
      end
    end
  end

  // Output register runs independently of the FSM so a pending word survives IDLE/FAIL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (load_collect) begin
      word_out   <= word_new;
      word_valid <= 1'b1;
    end else if (load_wait) begin
      word_out   <= sr;
      word_valid <= 1'b1;
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              rct_fail <= 1'b0;
    else if (health_fail) rct_fail <= 1'b1;
    else if (clr_fail)    rct_fail <= 1'b0;
  end

endmodule

// File: tb/tb_trng_bit_packer.sv
// Bench for trng_bit_packer: two configurations driven by directed and random stimulus,
// every output compared each cycle with a behavioural model of the packer.
module tb_trng_bit_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en_a = 0, b_a = 0, rdy_a = 0, clr_a = 0;
  logic [7:0] word_out_a;
  logic       word_valid_a, rct_fail_a;
  logic       en_b = 0, b_b = 0, rdy_b = 0, clr_b = 0;
  logic [3:0] word_out_b;
  logic       word_valid_b, rct_fail_b;

  trng_bit_packer #(.WORD_W(8), .SAMPLE_DIV(1), .RCT_LIMIT(4), .VN_EN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .bit_in(b_a),
    .word_out(word_out_a), .word_valid(word_valid_a), .word_ready(rdy_a),
    .rct_fail(rct_fail_a), .clr_fail(clr_a));

  trng_bit_packer #(.WORD_W(4), .SAMPLE_DIV(2), .RCT_LIMIT(8), .VN_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .bit_in(b_b),
    .word_out(word_out_b), .word_valid(word_valid_b), .word_ready(rdy_b),
    .rct_fail(rct_fail_b), .clr_fail(clr_b));

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model. Mode: 0 idle, 1 collecting, 2 waiting on output, 3 failed.
  int          m_mode[2], m_div[2], m_nbits[2], m_run[2], m_half[2];
  bit          m_pend[2], m_seen[2], m_last[2], m_valid[2], m_fail[2];
  logic [31:0] m_word[2], m_held[2], m_out[2];

  function automatic int cfg_w(input int k);   return (k == 0) ? 8 : 4; endfunction
  function automatic int cfg_div(input int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int cfg_lim(input int k); return (k == 0) ? 4 : 8; endfunction
  function automatic bit cfg_vn(input int k);  return (k == 0) ? 1'b0 : 1'b1; endfunction

  task automatic model_clear(input int k);
    m_div[k] = 0; m_nbits[k] = 0; m_run[k] = 0; m_half[k] = 0;
    m_pend[k] = 0; m_seen[k] = 0; m_last[k] = 0; m_word[k] = 0;
  endtask

  task automatic model_reset(input int k);
    model_clear(k);
    m_mode[k] = 0; m_valid[k] = 0; m_fail[k] = 0; m_held[k] = 0; m_out[k] = 0;
  endtask

  // Advance model k across one rising edge with the given inputs.
  task automatic model_step(input int k, input bit en, input bit b, input bit rdy, input bit clr);
    bit xfer, loaded, wipe, got, ab;
    xfer = m_valid[k] && rdy;
    loaded = 0; wipe = 0; got = 0; ab = 0;
    case (m_mode[k])
      0: if (en) m_mode[k] = 1;
      3: if (clr) begin m_fail[k] = 0; m_mode[k] = 0; end
      2: begin
        if (!en) begin m_mode[k] = 0; wipe = 1; end
        else if (rdy) begin m_out[k] = m_held[k]; loaded = 1; m_mode[k] = 1; end
      end
      default: begin
        if (m_div[k] == cfg_div(k) - 1) begin
          m_div[k] = 0;
          m_run[k] = (m_seen[k] && b == m_last[k]) ? m_run[k] + 1 : 1;
          m_seen[k] = 1;
          m_last[k] = b;
          if (m_run[k] == cfg_lim(k)) begin
            m_fail[k] = 1; m_mode[k] = 3; wipe = 1;
          end else begin
            if (!cfg_vn(k)) begin got = 1; ab = b; end
            else if (m_half[k] == 0) m_pend[k] = b;
            else if (m_pend[k] != b) begin got = 1; ab = m_pend[k]; end
            m_half[k] = 1 - m_half[k];
            if (got) begin
              m_word[k] = m_word[k] * 2 + 32'(ab);
              m_nbits[k]++;
              if (m_nbits[k] == cfg_w(k)) begin
                if (!m_valid[k] || rdy) begin m_out[k] = m_word[k]; loaded = 1; end
                else begin m_held[k] = m_word[k]; m_mode[k] = 2; end
                m_nbits[k] = 0; m_word[k] = 0;
              end
            end
          end
        end else begin
          m_div[k]++;
        end
        if (!en && m_mode[k] != 3) begin m_mode[k] = 0; wipe = 1; end
      end
    endcase
    if (wipe) model_clear(k);
    if (loaded)    m_valid[k] = 1;
    else if (xfer) m_valid[k] = 0;
  endtask

  task automatic compare_all();
    chk("a_valid", 32'(word_valid_a), 32'(m_valid[0]));
    chk("a_word",  32'(word_out_a),   m_out[0]);
    chk("a_fail",  32'(rct_fail_a),   32'(m_fail[0]));
    chk("b_valid", 32'(word_valid_b), 32'(m_valid[1]));
    chk("b_word",  32'(word_out_b),   m_out[1]);
    chk("b_fail",  32'(rct_fail_b),   32'(m_fail[1]));
  endtask

  // Inputs are already set; step the models and the DUTs across one edge, then compare.
  task automatic tick();
    model_step(0, en_a, b_a, rdy_a, clr_a);
    model_step(1, en_b, b_b, rdy_b, clr_b);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    chk("rst_a_valid", 32'(word_valid_a), 32'd0);
    chk("rst_a_word",  32'(word_out_a),   32'd0);
    chk("rst_a_fail",  32'(rct_fail_a),   32'd0);
    chk("rst_b_fail",  32'(rct_fail_b),   32'd0);
    chk("rst_b_valid", 32'(word_valid_b), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();
  endtask

  task automatic idle_inputs();
    en_a = 0; b_a = 0; rdy_a = 0; clr_a = 0;
    en_b = 0; b_b = 0; rdy_b = 0; clr_b = 0;
  endtask

  logic [7:0]  seq8;
  logic [11:0] seq12;

  initial begin
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("por_a_valid", 32'(word_valid_a), 32'd0);
    chk("por_a_word",  32'(word_out_a),   32'd0);
    chk("por_b_fail",  32'(rct_fail_b),   32'd0);
    rst = 1'b0;

    // Packing: 1,0,1,1,0,0,1,0 -> B2, valid for exactly one cycle.
    seq8 = 8'b1011_0010;
    rdy_a = 1; en_a = 1;
    tick();
    for (int i = 7; i >= 0; i--) begin
      b_a = seq8[i];
      tick();
      if (i == 1) chk("pack_early_valid", 32'(word_valid_a), 32'd0);
    end
    chk("pack_valid", 32'(word_valid_a), 32'd1);
    chk("pack_word",  32'(word_out_a),   32'hB2);
    en_a = 0;
    tick();
    chk("pack_one_cycle", 32'(word_valid_a), 32'd0);
    async_reset();

    // Debias: raw pairs 01,11,10,00,10,01 -> 0110.
    seq12 = 12'b01_11_10_00_10_01;
    rdy_b = 1; en_b = 1;
    tick();
    for (int i = 11; i >= 0; i--) begin
      b_b = seq12[i];
      tick();
      tick();
      if (i == 1) chk("vn_early_valid", 32'(word_valid_b), 32'd0);
    end
    chk("vn_valid", 32'(word_valid_b), 32'd1);
    chk("vn_word",  32'(word_out_b),   32'h6);
    idle_inputs();
    tick();
    async_reset();

    // Health failure: constant 1 fails on the 4th strobe; clr_fail recovers.
    en_a = 1; b_a = 1; rdy_a = 1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("rct_fail_step", 32'(rct_fail_a), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("rct_no_word", 32'(word_valid_a), 32'd0);
    tick();
    tick();
    chk("rct_sticky", 32'(rct_fail_a), 32'd1);
    clr_a = 1;
    tick();
    chk("rct_cleared", 32'(rct_fail_a), 32'd0);
    clr_a = 0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) clr_a = 1;
      tick();
      chk("rct_refail", 32'(rct_fail_a), (i == 4) ? 32'd1 : 32'd0);
    end
    tick();
    chk("rct_clr_again", 32'(rct_fail_a), 32'd0);
    idle_inputs();
    tick();
    async_reset();

    // Backpressure: AA held, second word CC parks in WAIT, then both move with no bubble.
    en_a = 1;
    tick();
    seq8 = 8'hAA;
    for (int i = 7; i >= 0; i--) begin b_a = seq8[i]; tick(); end
    chk("bp_first_word", 32'(word_out_a), 32'hAA);
    seq8 = 8'hCC;
    for (int i = 7; i >= 0; i--) begin
      b_a = seq8[i];
      tick();
      chk("bp_hold_word",  32'(word_out_a),   32'hAA);
      chk("bp_hold_valid", 32'(word_valid_a), 32'd1);
    end
    b_a = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_frozen", 32'(rct_fail_a), 32'd0);
    rdy_a = 1;
    tick();
    chk("bp_swap_word",  32'(word_out_a),   32'hCC);
    chk("bp_swap_valid", 32'(word_valid_a), 32'd1);
    en_a = 0;
    tick();
    chk("bp_drain", 32'(word_valid_a), 32'd0);
    idle_inputs();
    tick();

    // Enable drop after 5 bits: next word holds only post-re-enable bits.
    rdy_a = 1; en_a = 1;
    tick();
    seq8 = 8'b1101_1000;
    for (int i = 7; i >= 3; i--) begin b_a = seq8[i]; tick(); end
    en_a = 0; b_a = 0;
    tick();
    tick();
    en_a = 1;
    tick();
    seq8 = 8'h4B;
    for (int i = 7; i >= 0; i--) begin b_a = seq8[i]; tick(); end
    chk("reen_valid", 32'(word_valid_a), 32'd1);
    chk("reen_word",  32'(word_out_a),   32'h4B);
    idle_inputs();
    tick();

    // Async reset while A sits in WAIT and B is latched in FAIL.
    en_a = 1; en_b = 1; b_b = 1;
    for (int i = 0; i < 18; i++) begin
      b_a = (i % 2 == 1);
      tick();
    end
    chk("pre_rst_a_valid", 32'(word_valid_a), 32'd1);
    chk("pre_rst_b_fail",  32'(rct_fail_b),   32'd1);
    async_reset();
    idle_inputs();
    tick();

    // Randomised traffic; bias bit streams at times so the health test trips.
    for (int c = 0; c < 6000; c++) begin
      bit sticky;
      sticky = ((c / 400) % 2) == 1;
      en_a  = ($urandom_range(0, 99) < 96);
      en_b  = ($urandom_range(0, 99) < 97);
      rdy_a = ($urandom_range(0, 99) < 60);
      rdy_b = ($urandom_range(0, 99) < 40);
      clr_a = ($urandom_range(0, 99) < 6);
      clr_b = ($urandom_range(0, 99) < 6);
      b_a   = 1'($urandom);
      if (sticky && $urandom_range(0, 99) < 85) b_b = b_b;
      else                                      b_b = 1'($urandom);
      tick();
      if ($urandom_range(0, 999) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
